sifh_frame_sequencer: RTL and testbench
=======================================

Name: sifh_frame_sequencer

Overview:
- Frame-level controller for the SiFH histogram builder.
- Accepts TDC timestamps from an upstream valid/ready stream and clears the builder at frame start.
- Drives the builder write strobe and data through two passes per frame: coarse (pass 0) and fine (pass 1).
- Counts data/pixel/acquisition, waits out the builder pipeline after each pass, and flags pass and frame completion to the readout logic.

Parameters:
NP, 12, timestamp width (builder Np)
DATA_NUM, 2, timestamps per pixel per acquisition
PIXEL_NUM, 2, pixels per RAM
ACQ_NUM, 2, acquisitions per pass
CLR_CYCLES, 4, cycles builder held in reset at frame start (>=1)
DRAIN_CYCLES, 3, idle cycles after last write of a pass (builder pipeline depth, >=1)
TIMEOUT, 64, stall limit in cycles (optional feature only)

Ports:
clk  in  1  clock
res  in  1  reset; synchronous, active-high
start  in  1  one-cycle frame request
busy  out  1  high in any state except IDLE
s_valid  in  1  upstream timestamp valid
s_data  in  NP  upstream timestamp
s_ready  out  1  high only in STREAM
hb_res_n  out  1  builder reset, active-low
hb_wrEn  out  1  builder write strobe
hb_data  out  NP  builder data
hb_pass  out  1  current pass; 0 coarse, 1 fine
pixel_idx  out  8  pixel counter
acq_idx  out  20  acquisition counter
pass_done  out  1  one-cycle pulse at end of DRAIN
frame_done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset values: state IDLE, busy 0, s_ready 0, hb_res_n 0, hb_wrEn 0, hb_data 0, hb_pass 0, all counters 0, pulses 0.
- Reset mid-operation wins over everything and returns to IDLE next cycle.
- hb_res_n behaviour:
  - Stays 0 in IDLE after reset until the first frame's CLEAR completes.
  - After that it stays 1 in IDLE, so results remain readable.
- FSM IDLE -> CLEAR:
  - Transition on start=1.
  - CLEAR drives hb_res_n=0 for exactly CLR_CYCLES cycles and zeroes the counters and hb_pass.
  - start is ignored in every state except IDLE.
- FSM CLEAR -> STREAM: hb_res_n=1, s_ready=1.
- STREAM handshake:
  - Handshake = s_valid & s_ready.
  - On a handshake, next cycle hb_wrEn=1 and hb_data=s_data (registered, latency 1). Otherwise hb_wrEn=0 and hb_data holds.
  - The value 2^NP-1 is forwarded and counted like any other value; the builder discards it.
- Counters advance per handshake:
  - data_cnt wraps at DATA_NUM-1 and increments pixel_idx.
  - pixel_idx wraps at PIXEL_NUM-1 and increments acq_idx.
  - acq_idx wraps at ACQ_NUM-1.
- Last sample of a pass (all three counters at maximum):
  - s_ready drops the next cycle; no further handshake.
  - Counters wrap to 0.
  - Go to DRAIN.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles counted after the final hb_wrEn pulse; hb_wrEn=0 throughout.
  - On the last DRAIN cycle: pass_done=1.
  - If hb_pass=0: set hb_pass=1 and return to STREAM, without clearing the builder.
  - If hb_pass=1: go to DONE.
- DONE: frame_done=1 for one cycle, hb_pass returns to 0, then IDLE.
- Total accepted samples per frame: 2*DATA_NUM*PIXEL_NUM*ACQ_NUM.
- s_valid while not in STREAM is not accepted, since s_ready=0.

Optional Feature:
- Macro: SIFH_STALL_TIMEOUT_EN.
- With it defined:
  - A stall counter in STREAM counts consecutive cycles with s_valid=0 and resets on every handshake.
  - On reaching TIMEOUT, the sequencer injects a write of hb_data=2^NP-1 (hb_wrEn=1) next cycle, advances the counters as for a handshake, and resets the stall counter.
  - A pass therefore always completes.
- Without it: STREAM waits indefinitely and the stall counter logic is absent.

Decomposition:
- Shared package/header (alongside parametersSiFH.vh):
  - state encodings IDLE/CLEAR/STREAM/DRAIN/DONE;
  - NP, DATA_NUM, PIXEL_NUM, ACQ_NUM defaults;
  - INVALID_TS = 2^NP-1.
- One natural sub-module, sifh_nested_counter: a data/pixel/acq cascade with an advance input, a last flag and wrap outputs.

Test Plan:
- Reset then start; s_valid held 1 with s_data=0x010..0x017, then 0x020..0x027:
  - hb_res_n low for exactly 4 cycles.
  - 8 hb_wrEn pulses with hb_pass=0 and data 0x010..0x017, each one cycle after its handshake.
  - pass_done 3 cycles after the last write.
  - 8 further pulses with hb_pass=1, then frame_done, then busy=0.
- Toggling s_valid every other cycle: counters advance only on handshakes; pixel_idx sequence 0,0,1,1,0,0,1,1 per pass; acq_idx increments after sample 4.
- start pulsed during STREAM and DRAIN: ignored; the frame completes with exactly 16 writes and a single frame_done.
- res asserted mid-pass after 5 samples: next cycle IDLE, hb_res_n=0, counters 0, s_ready=0; a new start gives a full 16-sample frame.
- s_data=0xFFF accepted: forwarded with hb_wrEn=1 and counted toward the 8 per pass.
- With SIFH_STALL_TIMEOUT_EN and TIMEOUT=64: s_valid dropped after 3 samples causes a write of 0xFFF after 64 stall cycles. Holding s_valid=0 completes the frame using injected writes only.

Source files
------------

// File: rtl/sifh_frame_sequencer_pkg.sv
// sifh_frame_sequencer_pkg: shared FSM states, size defaults and the invalid-timestamp marker
package sifh_frame_sequencer_pkg;
    localparam int NP_DEF = 12;
    localparam int DATA_NUM_DEF = 2;
    localparam int PIXEL_NUM_DEF = 2;
    localparam int ACQ_NUM_DEF = 2;
    localparam logic [NP_DEF-1:0] INVALID_TS = '1;
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/sifh_nested_counter.sv
// sifh_nested_counter: data/pixel/acquisition cascade advanced once per accepted sample
// ports: clk, res (sync active-high), clr (zero all), adv (advance),
//        pixel_idx, acq_idx (current indices), last (all three at maximum)
module sifh_nested_counter
    import sifh_frame_sequencer_pkg::*;
#(
    parameter int DATA_NUM  = DATA_NUM_DEF,
    parameter int PIXEL_NUM = PIXEL_NUM_DEF,
    parameter int ACQ_NUM   = ACQ_NUM_DEF
) (
    input  logic        clk,
    input  logic        res,
    input  logic        clr,
    input  logic        adv,
    output logic [7:0]  pixel_idx,
    output logic [19:0] acq_idx,
    output logic        last
);
    logic [7:0] data_idx;
    logic data_wrap, pixel_wrap;
    assign data_wrap = data_idx == 8'(DATA_NUM - 1);
    assign pixel_wrap = data_wrap && pixel_idx == 8'(PIXEL_NUM - 1);
    assign last = pixel_wrap && acq_idx == 20'(ACQ_NUM - 1);
    always_ff @(posedge clk) begin
        if (res || clr) begin
            data_idx  <= '0;
            pixel_idx <= '0;
            acq_idx   <= '0;
        end else if (adv) begin
            data_idx  <= data_wrap ? '0 : data_idx + 8'd1;
            pixel_idx <= data_wrap ? (pixel_wrap ? '0 : pixel_idx + 8'd1) : pixel_idx;
            acq_idx   <= pixel_wrap ? (last ? '0 : acq_idx + 20'd1) : acq_idx;
        end
    end
endmodule

// File: rtl/sifh_frame_sequencer.sv
// sifh_frame_sequencer: clears the SiFH histogram builder and feeds it two passes of timestamps per frame
// ports: clk, res (sync active-high), start, busy; s_valid/s_data/s_ready upstream stream;
//        hb_res_n, hb_wrEn, hb_data, hb_pass builder side; pixel_idx, acq_idx, pass_done, frame_done status
// optional: SIFH_STALL_TIMEOUT_EN injects an invalid-timestamp write after TIMEOUT idle cycles in STREAM
module sifh_frame_sequencer
    import sifh_frame_sequencer_pkg::*;
#(
    parameter int NP           = NP_DEF,
    parameter int DATA_NUM     = DATA_NUM_DEF,
    parameter int PIXEL_NUM    = PIXEL_NUM_DEF,
    parameter int ACQ_NUM      = ACQ_NUM_DEF,
    parameter int CLR_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int TIMEOUT      = 64
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    output logic          busy,
    input  logic          s_valid,
    input  logic [NP-1:0] s_data,
    output logic          s_ready,
    output logic          hb_res_n,
    output logic          hb_wrEn,
    output logic [NP-1:0] hb_data,
    output logic          hb_pass,
    output logic [7:0]    pixel_idx,
    output logic [19:0]   acq_idx,
    output logic          pass_done,
    output logic          frame_done
);
    state_t state, state_nx;
    logic [15:0] tmr;
    logic cleared, hs, inj, adv, last;
    assign busy = state != IDLE;
    assign s_ready = state == STREAM;
    // builder stays in reset after power-up until the first clear; afterwards results stay readable in IDLE
    assign hb_res_n = cleared && state != CLEAR;
    // DRAIN also holds the cycle of the final registered write, so it ends DRAIN_CYCLES later
    assign pass_done = state == DRAIN && tmr == 16'(DRAIN_CYCLES);
    assign frame_done = state == DONE;
    assign hs = s_valid && s_ready;
    assign adv = hs || inj;
`ifdef SIFH_STALL_TIMEOUT_EN
    logic [15:0] stall;
    assign inj = s_ready && !s_valid && stall == 16'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        stall <= (res || !s_ready || s_valid || inj) ? '0 : stall + 16'd1;
    end
`else
    assign inj = 1'b0;
`endif
    sifh_nested_counter #(
        .DATA_NUM  (DATA_NUM),
        .PIXEL_NUM (PIXEL_NUM),
        .ACQ_NUM   (ACQ_NUM)
    ) u_cnt (
        .clk       (clk),
        .res       (res),
        .clr       (state == CLEAR),
        .adv       (adv),
        .pixel_idx (pixel_idx),
        .acq_idx   (acq_idx),
        .last      (last)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CLEAR : IDLE;
            CLEAR:   state_nx = tmr == 16'(CLR_CYCLES - 1) ? STREAM : CLEAR;
            STREAM:  state_nx = adv && last ? DRAIN : STREAM;
            DRAIN:   state_nx = pass_done ? (hb_pass ? DONE : STREAM) : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (res) begin
            state   <= IDLE;
            tmr     <= '0;
            cleared <= 1'b0;
            hb_wrEn <= 1'b0;
            hb_data <= '0;
            hb_pass <= 1'b0;
        end else begin
            state   <= state_nx;
            tmr     <= state_nx != state ? '0 : tmr + 16'd1;
            cleared <= cleared || (state == CLEAR && state_nx == STREAM);
            hb_wrEn <= adv;
            hb_data <= hs ? s_data : inj ? '1 : hb_data;
            hb_pass <= (state == CLEAR || state == DONE) ? 1'b0 : hb_pass || pass_done;
        end
    end
endmodule

// File: tb/tb_sifh_frame_sequencer.sv
// tb_sifh_frame_sequencer: randomized frames checked every cycle against a sample-count reference model
module tb_sifh_frame_sequencer;
    import sifh_frame_sequencer_pkg::*;
    localparam int NP = NP_DEF;
    localparam int PER_PIX = DATA_NUM_DEF;
    localparam int PER_ACQ = DATA_NUM_DEF * PIXEL_NUM_DEF;
    localparam int PER_PASS = PER_ACQ * ACQ_NUM_DEF;
    localparam int PER_FRAME = 2 * PER_PASS;
    localparam int CLR = 4, DRN = 3, TMO = 64;
    logic clk = 0, res = 1, start = 0, s_valid = 0;
    logic [NP-1:0] s_data = '0;
    logic busy, s_ready, hb_res_n, hb_wrEn, hb_pass, pass_done, frame_done;
    logic [NP-1:0] hb_data;
    logic [7:0] pixel_idx;
    logic [19:0] acq_idx;
    int n_chk = 0, n_fail = 0;
    int m_act = 0, m_clr = 0, m_k = 0, m_dr = -1, m_fin = 0, m_clrd = 0, m_wr = 0, m_stall = 0;
    logic [NP-1:0] m_data = '0;
    int wr_cnt, fd_cnt;

    sifh_frame_sequencer #(
        .NP(NP), .DATA_NUM(DATA_NUM_DEF), .PIXEL_NUM(PIXEL_NUM_DEF), .ACQ_NUM(ACQ_NUM_DEF),
        .CLR_CYCLES(CLR), .DRAIN_CYCLES(DRN), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .res(res), .start(start), .busy(busy),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .hb_res_n(hb_res_n), .hb_wrEn(hb_wrEn), .hb_data(hb_data), .hb_pass(hb_pass),
        .pixel_idx(pixel_idx), .acq_idx(acq_idx), .pass_done(pass_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_act != 0 && m_clr == 0 && m_dr < 0 && m_fin == 0;
    endfunction

    // frame position is tracked as samples accepted so far plus clear/drain countdowns
    task automatic model_step();
        bit hs, inj;
        hs = m_ready() && s_valid;
        inj = 0;
        if (res) begin
            m_act = 0; m_clr = 0; m_k = 0; m_dr = -1; m_fin = 0; m_clrd = 0; m_wr = 0; m_data = '0; m_stall = 0;
            return;
        end
`ifdef SIFH_STALL_TIMEOUT_EN
        if (m_ready() && !s_valid) begin
            inj = m_stall == TMO - 1;
            m_stall = inj ? 0 : m_stall + 1;
        end else m_stall = 0;
`endif
        m_wr = int'(hs || inj);
        if (hs) m_data = s_data;
        else if (inj) m_data = INVALID_TS;
        if (m_act == 0) begin
            if (start) begin m_act = 1; m_clr = CLR; m_k = 0; end
        end else if (m_clr > 0) begin
            m_clr--;
            if (m_clr == 0) m_clrd = 1;
        end else if (m_fin != 0) begin
            m_fin = 0; m_act = 0;
        end else if (m_dr >= 0) begin
            if (m_dr == DRN) begin m_dr = -1; m_fin = int'(m_k == PER_FRAME); end
            else m_dr++;
        end else if (hs || inj) begin
            m_k++;
            if (m_k % PER_PASS == 0) m_dr = 0;
        end
    endtask

    task automatic check_outputs();
        check("busy", busy, m_act);
        check("s_ready", s_ready, m_ready());
        check("hb_res_n", hb_res_n, m_clrd != 0 && m_clr == 0);
        check("hb_wrEn", hb_wrEn, m_wr);
        check("hb_data", hb_data, m_data);
        check("hb_pass", hb_pass, m_act != 0 && m_k >= PER_PASS && !(m_k == PER_PASS && m_dr >= 0));
        check("pixel_idx", pixel_idx, (m_k / PER_PIX) % PIXEL_NUM_DEF);
        check("acq_idx", acq_idx, (m_k / PER_ACQ) % ACQ_NUM_DEF);
        check("pass_done", pass_done, m_dr == DRN);
        check("frame_done", frame_done, m_fin);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        if (hb_wrEn) wr_cnt++;
        if (frame_done) fd_cnt++;
        start = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data = NP'($urandom);
            cycle();
        end
    endtask

    // mode 0: back-to-back 0x010../0x020..; 1: random; 2: valid every other cycle;
    // 3: random with stray start pulses; 4: valid never asserted
    task automatic run_frame(input int mode, input int abort_at);
        wr_cnt = 0;
        fd_cnt = 0;
        start = 1;
        cycle();
        for (int c = 0; m_act != 0 && c < 4000; c++) begin
            s_valid = mode == 0 ? 1'b1 : mode == 2 ? 1'(c % 2) : mode == 4 ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            if (mode == 0) s_data = m_k < PER_PASS ? NP'(12'h010 + m_k) : NP'(12'h020 + m_k - PER_PASS);
            else s_data = $urandom_range(0, 7) == 0 ? INVALID_TS : NP'($urandom);
            start = mode == 3 && $urandom_range(0, 4) == 0;
            if (abort_at >= 0 && m_k == abort_at && m_ready()) begin
                res = 1;
                cycle();
                res = 0;
                s_valid = 0;
                return;
            end
            cycle();
        end
        s_valid = 0;
        check("busy_end", busy, 0);
        check("writes", wr_cnt, PER_FRAME);
        check("frame_done_cnt", fd_cnt, 1);
    endtask

    initial begin
        res = 1;
        cycle();
        cycle();
        res = 0;
        idle(3);
        run_frame(0, -1);
        idle(2);
        run_frame(2, -1);
        run_frame(3, -1);
        run_frame(0, 5);
        idle(2);
        run_frame(0, -1);
        for (int i = 0; i < 6; i++) begin
            run_frame(1, -1);
            idle($urandom_range(0, 3));
        end
`ifdef SIFH_STALL_TIMEOUT_EN
        run_frame(4, -1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
